stopwatch_timer_core: RTL and testbench

//  Parametrised MM:SS stopwatch/timer core. Next generation of the lab3 stopwatch top.

---
 rtl/stopwatch_pkg.sv | 23 ++
 rtl/stopwatch_timer_core_tick_divider.sv | 29 ++
 rtl/stopwatch_timer_core.sv | 179 +++++++++++++++++
 tb/tb_stopwatch_timer_core.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, limits and the binary-to-BCD helper for the MM:SS stopwatch core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd2
    } run_state_t;

    localparam int SEC_MAX = 59;

    // Two-digit conversion; inputs above 99 clamp so the tens digit never exceeds 9.
    function automatic logic [7:0] bin2bcd2(input logic [6:0] bin);
        logic [6:0] val;
        logic [3:0] tens;
        logic [3:0] ones;
        val  = (bin > 7'd99) ? 7'd99 : bin;
        tens = 4'(val / 7'd10);
        ones = 4'(val % 7'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/stopwatch_timer_core_tick_divider.sv
// Free-running divider producing a one-cycle tick every DIV cycles; held at zero while clr is high.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Tick is gated by clr so the first tick lands exactly DIV cycles after release.
    assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/stopwatch_timer_core.sv
// MM:SS stopwatch/timer: run-state FSM, time registers, adjust, lap hold and registered BCD outputs.
module stopwatch_timer_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int COUNT_HZ = 1,
    parameter int ADJ_HZ   = 2,
    parameter int MIN_MAX  = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pause_pulse,
    input  logic       clear_pulse,
    input  logic       lap_pulse,
    input  logic       adj,
    input  logic       sel,
    input  logic       mode_down,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       rollover,
    output logic       lap_active
);

    localparam int            COUNT_DIV = CLK_HZ / COUNT_HZ;
    localparam int            ADJ_DIV   = CLK_HZ / ADJ_HZ;
    localparam int            MW        = (MIN_MAX > 1) ? $clog2(MIN_MAX + 1) : 1;
    localparam logic [MW-1:0] MIN_TOP   = MW'(MIN_MAX);
    localparam logic [5:0]    SEC_TOP   = 6'(SEC_MAX);

    run_state_t    state;
    run_state_t    state_next;
    logic [5:0]    sec_val;
    logic [5:0]    sec_next;
    logic [MW-1:0] min_val;
    logic [MW-1:0] min_next;
    logic          lap;
    logic          lap_next;
    logic          wrap;
    logic          wrap_next;
    logic          reach_zero;
    logic          count_tick;
    logic          adj_tick;
    logic          count_clr;
    logic          adj_clr;
    logic [7:0]    min_bcd;
    logic [7:0]    sec_bcd;

    assign count_clr = !((state == RUN) && !adj);
    assign adj_clr   = !adj;

    tick_divider #(.DIV(COUNT_DIV)) u_count_div (
        .clk   (clk),
        .reset (reset),
        .clr   (count_clr),
        .tick  (count_tick)
    );

    tick_divider #(.DIV(ADJ_DIV)) u_adj_div (
        .clk   (clk),
        .reset (reset),
        .clr   (adj_clr),
        .tick  (adj_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= PAUSED;
        end else begin
            state <= state_next;
        end
    end

    // The tick is evaluated against the current state; pause_pulse then decides the next state.
    always_comb begin
        state_next = state;
        sec_next   = sec_val;
        min_next   = min_val;
        lap_next   = lap ^ lap_pulse;
        wrap_next  = 1'b0;
        reach_zero = 1'b0;

        if (clear_pulse) begin
            state_next = PAUSED;
            sec_next   = '0;
            min_next   = '0;
            lap_next   = 1'b0;
        end else begin
            if (adj) begin
                if (adj_tick) begin
                    if (sel) begin
                        sec_next = (sec_val == SEC_TOP) ? '0 : sec_val + 6'd1;
                    end else begin
                        min_next = (min_val == MIN_TOP) ? '0 : min_val + MW'(1);
                    end
                end
            end else if (count_tick) begin
                if (mode_down) begin
                    if ((sec_val == '0) && (min_val == '0)) begin
                        reach_zero = 1'b1;
                    end else if (sec_val == '0) begin
                        sec_next = SEC_TOP;
                        min_next = min_val - MW'(1);
                    end else begin
                        sec_next   = sec_val - 6'd1;
                        reach_zero = (min_val == '0) && (sec_val == 6'd1);
                    end
                end else begin
                    if (sec_val == SEC_TOP) begin
                        sec_next = '0;
                        if (min_val == MIN_TOP) begin
                            min_next  = '0;
                            wrap_next = 1'b1;
                        end else begin
                            min_next = min_val + MW'(1);
                        end
                    end else begin
                        sec_next = sec_val + 6'd1;
                    end
                end
            end

            if (pause_pulse) begin
                case (state)
                    PAUSED:  state_next = RUN;
                    default: state_next = PAUSED;
                endcase
            end else if (reach_zero) begin
                state_next = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_val <= '0;
            min_val <= '0;
            lap     <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            sec_val <= sec_next;
            min_val <= min_next;
            lap     <= lap_next;
            wrap    <= wrap_next;
        end
    end

    assign min_bcd = bin2bcd2(7'(min_val));
    assign sec_bcd = bin2bcd2(7'(sec_val));

    // Output stage: one cycle behind the time registers. Display freezes only while lap stays held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            rollover <= 1'b0;
        end else begin
            if (!(lap && lap_next)) begin
                min_tens <= min_bcd[7:4];
                min_ones <= min_bcd[3:0];
                sec_tens <= sec_bcd[7:4];
                sec_ones <= sec_bcd[3:0];
            end
            running  <= (state == RUN);
            done     <= (state == DONE);
            rollover <= wrap;
        end
    end

    assign lap_active = lap;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Directed bench for stopwatch_timer_core with scaled clock rates (count every 20 cycles, adjust every 10).
module tb_stopwatch_timer_core;

    logic       clk;
    logic       reset;
    logic       pause_pulse;
    logic       clear_pulse;
    logic       lap_pulse;
    logic       adj;
    logic       sel;
    logic       mode_down;

    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done, rollover, lap_active;
    logic [3:0] min_tens2, min_ones2, sec_tens2, sec_ones2;
    logic       running2, done2, rollover2, lap_active2;

    logic [15:0] disp;
    logic [15:0] disp2;
    assign disp  = {min_tens, min_ones, sec_tens, sec_ones};
    assign disp2 = {min_tens2, min_ones2, sec_tens2, sec_ones2};

    int total;
    int bad;

    stopwatch_timer_core #(.CLK_HZ(20), .COUNT_HZ(1), .ADJ_HZ(2), .MIN_MAX(99)) dut (
        .clk         (clk),
        .reset       (reset),
        .pause_pulse (pause_pulse),
        .clear_pulse (clear_pulse),
        .lap_pulse   (lap_pulse),
        .adj         (adj),
        .sel         (sel),
        .mode_down   (mode_down),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .running     (running),
        .done        (done),
        .rollover    (rollover),
        .lap_active  (lap_active)
    );

    stopwatch_timer_core #(.CLK_HZ(20), .COUNT_HZ(1), .ADJ_HZ(2), .MIN_MAX(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .pause_pulse (pause_pulse),
        .clear_pulse (clear_pulse),
        .lap_pulse   (lap_pulse),
        .adj         (adj),
        .sel         (sel),
        .mode_down   (mode_down),
        .min_tens    (min_tens2),
        .min_ones    (min_ones2),
        .sec_tens    (sec_tens2),
        .sec_ones    (sec_ones2),
        .running     (running2),
        .done        (done2),
        .rollover    (rollover2),
        .lap_active  (lap_active2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_pause();
        pause_pulse = 1'b1;
        wait_cycles(1);
        pause_pulse = 1'b0;
    endtask

    task automatic pulse_lap();
        lap_pulse = 1'b1;
        wait_cycles(1);
        lap_pulse = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(1);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        pause_pulse = 1'b0;
        clear_pulse = 1'b0;
        lap_pulse   = 1'b0;
        adj         = 1'b0;
        sel         = 1'b0;
        mode_down   = 1'b0;

        // Reset state
        wait_cycles(3);
        check_val("rst_disp", 32'(disp), 32'h0000);
        check_val("rst_flags", {running, done, rollover, lap_active}, 4'b0000);
        check_val("rst_disp2", 32'(disp2), 32'h0000);
        check_val("rst_flags2", {running2, done2, rollover2, lap_active2}, 4'b0000);
        reset = 1'b1;
        wait_cycles(1);

        // 1: count up 61 ticks, then pause
        pulse_pause();
        wait_cycles(1221);
        check_val("up_0101", 32'(disp), 32'h0101);
        check_val("up_running", 32'(running), 32'd1);
        pulse_pause();
        wait_cycles(100);
        check_val("pause_frozen", 32'(disp), 32'h0101);
        check_val("pause_running", 32'(running), 32'd0);

        // 2: preload 00:02, count down to DONE
        do_reset();
        adj = 1'b1;
        sel = 1'b1;
        wait_cycles(20);
        adj       = 1'b0;
        mode_down = 1'b1;
        pulse_pause();
        wait_cycles(41);
        check_val("down_disp", 32'(disp), 32'h0000);
        check_val("down_done", 32'(done), 32'd1);
        check_val("down_running", 32'(running), 32'd0);
        wait_cycles(40);
        check_val("done_hold_disp", 32'(disp), 32'h0000);
        check_val("done_hold", 32'(done), 32'd1);
        pulse_pause();
        wait_cycles(1);
        check_val("done_leave", 32'(done), 32'd0);

        // 3: adjust wraps without carry
        do_reset();
        mode_down = 1'b0;
        adj = 1'b1;
        sel = 1'b0;
        wait_cycles(990);
        sel = 1'b1;
        wait_cycles(581);
        check_val("adj_9958", 32'(disp), 32'h9958);
        wait_cycles(20);
        check_val("adj_sec_wrap", 32'(disp), 32'h9900);
        sel = 1'b0;
        wait_cycles(10);
        check_val("adj_min_wrap", 32'(disp), 32'h0000);
        adj = 1'b0;

        // 4: MIN_MAX=2 rollover
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        wait_cycles(20);
        sel = 1'b1;
        wait_cycles(590);
        adj = 1'b0;
        pulse_pause();
        check_val("roll_pre", 32'(disp2), 32'h0259);
        wait_cycles(20);
        check_val("roll_before", 32'(rollover2), 32'd0);
        wait_cycles(1);
        check_val("roll_pulse", 32'(rollover2), 32'd1);
        check_val("roll_disp", 32'(disp2), 32'h0000);
        wait_cycles(1);
        check_val("roll_after", 32'(rollover2), 32'd0);
        check_val("roll_running", 32'(running2), 32'd1);

        // 5: lap hold
        do_reset();
        pulse_pause();
        wait_cycles(101);
        check_val("lap_pre", 32'(disp), 32'h0005);
        pulse_lap();
        check_val("lap_set", 32'(lap_active), 32'd1);
        wait_cycles(60);
        check_val("lap_frozen", 32'(disp), 32'h0005);
        pulse_lap();
        check_val("lap_release", 32'(disp), 32'h0008);
        check_val("lap_off", 32'(lap_active), 32'd0);

        // 6: asynchronous reset mid-cycle, then clear with pause
        wait_cycles(5);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_disp", 32'(disp), 32'h0000);
        check_val("arst_running", 32'(running), 32'd0);
        wait_cycles(2);
        reset = 1'b1;
        wait_cycles(30);
        check_val("arst_paused", {16'(disp), 15'd0, running}, 32'h0);
        pulse_pause();
        wait_cycles(45);
        check_val("clr_pre", 32'(disp), 32'h0002);
        clear_pulse = 1'b1;
        pause_pulse = 1'b1;
        wait_cycles(1);
        clear_pulse = 1'b0;
        pause_pulse = 1'b0;
        wait_cycles(2);
        check_val("clr_disp", 32'(disp), 32'h0000);
        check_val("clr_running", 32'(running), 32'd0);
        wait_cycles(40);
        check_val("clr_paused", 32'(disp), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
